// File: rtl/axis_channel_packer.sv
// Block-averages six signed sample streams per frame and serializes a header plus the
// enabled channel results onto one back-pressured AXI-Stream; busy-time frames are dropped.
module axis_channel_packer #(
  parameter int unsigned SAXIS_TDATA_WIDTH = 32,
  parameter int unsigned MAXIS_TDATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH         = 48
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_1_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_2_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_3_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_4_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_5_tdata,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_6_tdata,
  input  logic                         S_AXIS_1_tvalid,
  input  logic                         S_AXIS_2_tvalid,
  input  logic                         S_AXIS_3_tvalid,
  input  logic                         S_AXIS_4_tvalid,
  input  logic                         S_AXIS_5_tvalid,
  input  logic                         S_AXIS_6_tvalid,
  input  logic                         run,
  input  logic [5:0]                   channel_mask,
  input  logic [15:0]                  decimation,
  input  logic [4:0]                   shift,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic                         M_AXIS_tlast,
  output logic [15:0]                  frame_count,
  output logic [15:0]                  overrun_count,
  output logic                         overrun
);

  localparam int unsigned MW = MAXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  logic unused_tvalid;
  assign unused_tvalid = ^{S_AXIS_2_tvalid, S_AXIS_3_tvalid, S_AXIS_4_tvalid,
                           S_AXIS_5_tvalid, S_AXIS_6_tvalid};

  logic signed [SAXIS_TDATA_WIDTH-1:0] din [6];
  assign din[0] = S_AXIS_1_tdata;
  assign din[1] = S_AXIS_2_tdata;
  assign din[2] = S_AXIS_3_tdata;
  assign din[3] = S_AXIS_4_tdata;
  assign din[4] = S_AXIS_5_tdata;
  assign din[5] = S_AXIS_6_tdata;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q [6];
  logic signed [ACC_WIDTH-1:0] acc_d [6];
  logic [MW-1:0]               res_q [6];
  logic [MW-1:0]               res_d [6];
  logic [15:0]                 cnt_q, cnt_d, dec_c_q, dec_c_d;
  logic [5:0]                  mask_c_q, mask_c_d, mask_f_q, mask_f_d;
  logic [4:0]                  shift_c_q, shift_c_d;
  logic [2:0]                  idx_q, idx_d;
  logic [15:0]                 frame_count_q, frame_count_d;
  logic [15:0]                 overrun_count_q, overrun_count_d;
  logic                        overrun_q, overrun_d, run_q;

  logic                        strobe, done, hs, has_nxt;
  logic [16:0]                 cnt_inc;
  logic [15:0]                 dec_eff, n_eff;
  logic [5:0]                  mask_eff;
  logic [4:0]                  shift_eff;
  logic [2:0]                  first_idx, nxt_idx;
  logic signed [ACC_WIDTH-1:0] sum [6];
  logic signed [ACC_WIDTH-1:0] sh [6];
  logic [MW-1:0]               sat [6];
  logic [ACC_WIDTH-MW:0]       hi;

  always_comb begin
    strobe    = run && S_AXIS_1_tvalid;
    // The first strobe of a frame uses the live config; later strobes use the latched copy.
    mask_eff  = (cnt_q == 16'd0) ? channel_mask : mask_c_q;
    dec_eff   = (cnt_q == 16'd0) ? decimation   : dec_c_q;
    shift_eff = (cnt_q == 16'd0) ? shift        : shift_c_q;
    n_eff     = (dec_eff == 16'd0) ? 16'd1 : dec_eff;
    cnt_inc   = {1'b0, cnt_q} + 17'd1;
    done      = strobe && (cnt_inc == {1'b0, n_eff});

    mask_c_d  = mask_c_q;
    dec_c_d   = dec_c_q;
    shift_c_d = shift_c_q;
    if (strobe && cnt_q == 16'd0) begin
      mask_c_d  = channel_mask;
      dec_c_d   = decimation;
      shift_c_d = shift;
    end

    cnt_d = cnt_q;
    if (!run)        cnt_d = '0;
    else if (strobe) cnt_d = done ? '0 : cnt_inc[15:0];

    hi = '0;
    for (int k = 0; k < 6; k++) begin
      sum[k] = acc_q[k] + ACC_WIDTH'(din[k]);
      sh[k]  = sum[k] >>> shift_eff;
      hi     = sh[k][ACC_WIDTH-1:MW-1];
      if ((&hi) || !(|hi)) sat[k] = sh[k][MW-1:0];
      else                 sat[k] = sh[k][ACC_WIDTH-1] ? {1'b1, {(MW-1){1'b0}}}
                                                       : {1'b0, {(MW-1){1'b1}}};
      acc_d[k] = acc_q[k];
      if (!run)        acc_d[k] = '0;
      else if (strobe) acc_d[k] = done ? '0 : sum[k];
    end
  end

  // Channel walk: lowest enabled channel, and the next enabled channel above idx_q.
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    has_nxt   = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      if (mask_f_q[k]) first_idx = 3'(k);
      if (mask_f_q[k] && (3'(k) > idx_q)) begin
        nxt_idx = 3'(k);
        has_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    M_AXIS_tvalid = (state_q != StIdle);
    M_AXIS_tlast  = ((state_q == StHdr) && (mask_f_q == 6'd0)) ||
                    ((state_q == StData) && !has_nxt);
    M_AXIS_tdata  = '0;
    if (state_q == StHdr)       M_AXIS_tdata = MW'({8'hA5, 2'b00, mask_f_q, frame_count_q});
    else if (state_q == StData) M_AXIS_tdata = res_q[idx_q];
    hs = M_AXIS_tvalid && M_AXIS_tready;

    state_d         = state_q;
    idx_d           = idx_q;
    res_d           = res_q;
    mask_f_d        = mask_f_q;
    frame_count_d   = frame_count_q;
    overrun_count_d = overrun_count_q;
    overrun_d       = overrun_q;

    if (run && !run_q) overrun_d = 1'b0;
    if (done && state_q != StIdle) begin
      overrun_d = 1'b1;
      if (overrun_count_q != 16'hFFFF) overrun_count_d = overrun_count_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (done) begin
          state_d  = StHdr;
          res_d    = sat;
          mask_f_d = mask_eff;
        end
      end
      StHdr: begin
        if (hs) begin
          if (mask_f_q != 6'd0) begin
            state_d = StData;
            idx_d   = first_idx;
          end else begin
            state_d       = StIdle;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      StData: begin
        if (hs) begin
          if (has_nxt) begin
            idx_d = nxt_idx;
          end else begin
            state_d       = StIdle;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      dec_c_q         <= '0;
      mask_c_q        <= '0;
      shift_c_q       <= '0;
      mask_f_q        <= '0;
      idx_q           <= '0;
      frame_count_q   <= '0;
      overrun_count_q <= '0;
      overrun_q       <= 1'b0;
      run_q           <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dec_c_q         <= dec_c_d;
      mask_c_q        <= mask_c_d;
      shift_c_q       <= shift_c_d;
      mask_f_q        <= mask_f_d;
      idx_q           <= idx_d;
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
      overrun_q       <= overrun_d;
      run_q           <= run;
      for (int k = 0; k < 6; k++) begin
        acc_q[k] <= acc_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_count_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_channel_packer.sv
// Directed bench for axis_channel_packer: averaging, saturation, back-pressure, overrun,
// edge configurations and asynchronous reset, with hand-computed expected words.
module tb_axis_channel_packer;

  logic        a_clk = 1'b0;
  logic        a_resetn;
  logic [31:0] din [6];
  logic        tvalid;
  logic        run;
  logic [5:0]  channel_mask;
  logic [15:0] decimation;
  logic [4:0]  shift;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
  logic [15:0] frame_count, overrun_count;
  logic        overrun;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] got  [16];
  logic        gotl [16];

  always #5 a_clk = ~a_clk;

  axis_channel_packer dut (
    .a_clk           (a_clk),
    .a_resetn        (a_resetn),
    .S_AXIS_1_tdata  (din[0]),
    .S_AXIS_2_tdata  (din[1]),
    .S_AXIS_3_tdata  (din[2]),
    .S_AXIS_4_tdata  (din[3]),
    .S_AXIS_5_tdata  (din[4]),
    .S_AXIS_6_tdata  (din[5]),
    .S_AXIS_1_tvalid (tvalid),
    .S_AXIS_2_tvalid (1'b0),
    .S_AXIS_3_tvalid (1'b0),
    .S_AXIS_4_tvalid (1'b0),
    .S_AXIS_5_tvalid (1'b0),
    .S_AXIS_6_tvalid (1'b0),
    .run             (run),
    .channel_mask    (channel_mask),
    .decimation      (decimation),
    .shift           (shift),
    .M_AXIS_tdata    (M_AXIS_tdata),
    .M_AXIS_tvalid   (M_AXIS_tvalid),
    .M_AXIS_tready   (M_AXIS_tready),
    .M_AXIS_tlast    (M_AXIS_tlast),
    .frame_count     (frame_count),
    .overrun_count   (overrun_count),
    .overrun         (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge a_clk);
  endtask

  task automatic strobe(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] v3, input logic [31:0] v4, input logic [31:0] v5);
    din[0] = v0; din[1] = v1; din[2] = v2; din[3] = v3; din[4] = v4; din[5] = v5;
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
  endtask

  // Accepts words with tready high until n have transferred or the cycle budget runs out.
  task automatic collect(input int n);
    int k = 0;
    int cyc = 0;
    M_AXIS_tready = 1'b1;
    while (k < n && cyc < 50) begin
      if (M_AXIS_tvalid) begin
        got[k]  = M_AXIS_tdata;
        gotl[k] = M_AXIS_tlast;
        k++;
      end
      step();
      cyc++;
    end
    chk("collect_count", 32'(k), 32'(n));
  endtask

  logic [31:0] exp3 [7];
  logic        rpat [4];
  logic [31:0] pd;
  logic        pl, prev_stall;
  int          k3, cyc3;

  initial begin
    a_resetn = 1'b0; tvalid = 1'b0; run = 1'b0; channel_mask = '0; decimation = '0;
    shift = '0; M_AXIS_tready = 1'b0;
    for (int i = 0; i < 6; i++) din[i] = '0;
    step(); step();
    chk("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_tlast", 32'(M_AXIS_tlast), 32'd0);
    chk("rst_tdata", M_AXIS_tdata, 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_overrun_count", 32'(overrun_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    a_resetn = 1'b1;
    step();

    // Basic averaging
    run = 1'b1; M_AXIS_tready = 1'b1;
    decimation = 16'd4; shift = 5'd2; channel_mask = 6'b000011;
    strobe(32'd10, -32'sd4, 0, 0, 0, 0);
    strobe(32'd20, -32'sd4, 0, 0, 0, 0);
    strobe(32'd30, -32'sd4, 0, 0, 0, 0);
    strobe(32'd40, -32'sd4, 0, 0, 0, 0);
    chk("avg_latency_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    collect(3);
    chk("avg_hdr", got[0], 32'hA503_0000);
    chk("avg_ch1", got[1], 32'd25);
    chk("avg_ch2", got[2], 32'hFFFF_FFFC);
    chk("avg_last", {29'd0, gotl[0], gotl[1], gotl[2]}, 32'b001);
    chk("avg_frame_count", 32'(frame_count), 32'd1);

    // Saturation, both signs
    decimation = 16'd2; shift = 5'd0; channel_mask = 6'b000100;
    strobe(0, 0, 32'h7FFF_FFFF, 0, 0, 0);
    strobe(0, 0, 32'h7FFF_FFFF, 0, 0, 0);
    collect(2);
    chk("sat_pos_hdr", got[0], 32'hA504_0001);
    chk("sat_pos", got[1], 32'h7FFF_FFFF);
    strobe(0, 0, 32'h8000_0000, 0, 0, 0);
    strobe(0, 0, 32'h8000_0000, 0, 0, 0);
    collect(2);
    chk("sat_neg_hdr", got[0], 32'hA504_0002);
    chk("sat_neg", got[1], 32'h8000_0000);

    // Back-pressure on a full 7-word frame
    decimation = 16'd8; shift = 5'd3; channel_mask = 6'h3F;
    for (int i = 0; i < 8; i++) strobe(1, -32'sd2, 3, -32'sd4, 5, -32'sd6);
    exp3[0] = 32'hA53F_0003; exp3[1] = 32'd1; exp3[2] = 32'hFFFF_FFFE; exp3[3] = 32'd3;
    exp3[4] = 32'hFFFF_FFFC; exp3[5] = 32'd5; exp3[6] = 32'hFFFF_FFFA;
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
    prev_stall = 1'b0; pd = '0; pl = 1'b0; k3 = 0; cyc3 = 0;
    while (k3 < 7 && cyc3 < 60) begin
      M_AXIS_tready = rpat[cyc3 % 4];
      if (prev_stall) begin
        chk("bp_hold_valid", 32'(M_AXIS_tvalid), 32'd1);
        chk("bp_hold_data", M_AXIS_tdata, pd);
        chk("bp_hold_last", 32'(M_AXIS_tlast), 32'(pl));
      end
      prev_stall = 1'b0;
      if (M_AXIS_tvalid) begin
        if (M_AXIS_tready) begin
          got[k3] = M_AXIS_tdata; gotl[k3] = M_AXIS_tlast; k3++;
        end else begin
          prev_stall = 1'b1; pd = M_AXIS_tdata; pl = M_AXIS_tlast;
        end
      end
      step();
      cyc3++;
    end
    chk("bp_count", 32'(k3), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_word%0d", i), got[i], exp3[i]);
      chk($sformatf("bp_last%0d", i), 32'(gotl[i]), (i == 6) ? 32'd1 : 32'd0);
    end

    // Overrun: one accepted frame, twenty dropped while stalled
    decimation = 16'd1; shift = 5'd0; channel_mask = 6'h3F; M_AXIS_tready = 1'b0;
    strobe(32'd1000, 32'd1001, 32'd1002, 32'd1003, 32'd1004, 32'd1005);
    for (int i = 0; i < 20; i++) strobe(7, 7, 7, 7, 7, 7);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(overrun_count), 32'd20);
    chk("ovr_hdr_held", M_AXIS_tdata, 32'hA53F_0004);
    collect(7);
    chk("ovr_hdr", got[0], 32'hA53F_0004);
    for (int i = 1; i < 7; i++) chk($sformatf("ovr_ch%0d", i), got[i], 32'(999 + i));
    chk("ovr_last", 32'(gotl[6]), 32'd1);
    run = 1'b0; step();
    run = 1'b1; step();
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_count_kept", 32'(overrun_count), 32'd20);

    // Decimation 0 with mask 0: header-only frames
    decimation = 16'd0; channel_mask = 6'd0;
    strobe(1, 1, 1, 1, 1, 1);
    chk("hdr_only_valid", 32'(M_AXIS_tvalid), 32'd1);
    chk("hdr_only_word", M_AXIS_tdata, 32'hA500_0005);
    chk("hdr_only_last", 32'(M_AXIS_tlast), 32'd1);
    step();
    strobe(1, 1, 1, 1, 1, 1);
    chk("hdr_only_word2", M_AXIS_tdata, 32'hA500_0006);
    chk("hdr_only_last2", 32'(M_AXIS_tlast), 32'd1);
    step();
    chk("hdr_only_idle", 32'(M_AXIS_tvalid), 32'd0);

    // Mask change mid-frame applies to the next frame only
    decimation = 16'd3; channel_mask = 6'b000001;
    strobe(1, 32'd50, 0, 0, 0, 0);
    channel_mask = 6'b000010;
    strobe(1, 32'd50, 0, 0, 0, 0);
    strobe(1, 32'd50, 0, 0, 0, 0);
    collect(2);
    chk("mask_mid_hdr", got[0], 32'hA501_0007);
    chk("mask_mid_data", got[1], 32'd3);
    chk("mask_mid_last", 32'(gotl[1]), 32'd1);
    for (int i = 0; i < 3; i++) strobe(1, 32'd50, 0, 0, 0, 0);
    collect(2);
    chk("mask_next_hdr", got[0], 32'hA502_0008);
    chk("mask_next_data", got[1], 32'd150);

    // Asynchronous reset while in DATA
    decimation = 16'd8; channel_mask = 6'h3F;
    for (int i = 0; i < 8; i++) strobe(0, 0, 0, 0, 0, 0);
    M_AXIS_tready = 1'b1;
    step(); step();
    chk("rst_mid_in_data", 32'(M_AXIS_tvalid), 32'd1);
    a_resetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_mid_tlast", 32'(M_AXIS_tlast), 32'd0);
    chk("rst_mid_tdata", M_AXIS_tdata, 32'd0);
    chk("rst_mid_frame_count", 32'(frame_count), 32'd0);
    chk("rst_mid_overrun_count", 32'(overrun_count), 32'd0);
    step();
    a_resetn = 1'b1;
    step();
    decimation = 16'd2; channel_mask = 6'b000001; shift = 5'd0;
    strobe(32'd4, 0, 0, 0, 0, 0);
    strobe(32'd4, 0, 0, 0, 0, 0);
    collect(2);
    chk("post_rst_hdr", got[0], 32'hA501_0000);
    chk("post_rst_data", got[1], 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_channel_packer.md
# axis_channel_packer

Downstream consumer of the 6-output AXIS channel selector. Per frame, it block-averages up to six selected 32-bit signed streams over a programmable number of samples, then serializes one header word plus the enabled channel results onto a single back-pressured AXI-Stream for the DMA/FIFO path. Frames that complete while the serializer is busy are dropped and counted.

## Interface
- `SAXIS_TDATA_WIDTH`, 32: width of each input channel, signed.
- `MAXIS_TDATA_WIDTH`, 32: output word width.
- `ACC_WIDTH`, 48: accumulator width (`SAXIS_TDATA_WIDTH` + 16).

- `a_clk` in 1: single clock, rising edge.
- `a_resetn` in 1: asynchronous, active-low reset.
- `S_AXIS_1_tdata` … `S_AXIS_6_tdata` in 32 each: selected channel samples, signed.
- `S_AXIS_1_tvalid` in 1: common sample strobe for all six channels.
- `S_AXIS_2_tvalid` … `S_AXIS_6_tvalid` in 1 each: ignored, kept for bus compatibility.
- `run` in 1: enables accumulation. When low, accumulators and the sample count are cleared.
- `channel_mask` in 6: bit k enables channel k+1 in the output frame.
- `decimation` in 16: samples per frame, N. A value of 0 is treated as 1.
- `shift` in 5: arithmetic right shift applied to each sum.
- `M_AXIS_tdata` out 32: packed output word.
- `M_AXIS_tvalid` out 1: output word valid.
- `M_AXIS_tready` in 1: downstream ready.
- `M_AXIS_tlast` out 1: marks the last word of a frame.
- `frame_count` out 16: frames emitted, wraps.
- `overrun_count` out 16: frames dropped, saturates at 0xFFFF.
- `overrun` out 1: sticky drop flag. Cleared only by reset or by a `run` rising edge.

## Operation
- **Config latch:** `channel_mask`, `decimation` and `shift` are latched when the sample count is 0 and the first strobe of a frame arrives. Mid-frame changes do not affect the current frame.
- **Accumulate:** on each cycle with `run`=1 and `S_AXIS_1_tvalid`=1:
  - acc[k] += sign-extended `S_AXIS_k_tdata` for all k.
  - cnt increments.
  - When cnt reaches N, that sample is included, the frame completes, and cnt and the accumulators restart at 0 on the next strobe. There is no dead cycle.
- **Result:** r[k] = acc[k] >>> shift (arithmetic), saturated to [-2^31, 2^31-1]. The result is latched into the frame buffer on the completing cycle.
- **Header word:** {8'hA5, 2'b00, mask[5:0], frame_count[15:0]}. `frame_count` is the value before increment.
- **Frame layout:** header, then r[k] for each set mask bit in ascending k. `M_AXIS_tlast` is asserted on the final word. With mask=0 the frame is the header alone, with tlast=1.
- **State machine:**
  - IDLE → HDR when a frame completes.
  - HDR → DATA on handshake if mask≠0, else → IDLE.
  - DATA steps through the enabled channels on each handshake. After the last one it returns → IDLE.
  - A frame completing while the state is not IDLE is dropped. The in-flight frame is unaffected, `overrun_count` increments, and `overrun` is set.
- `frame_count` increments on the tlast handshake.
- **`run` falling edge:** the partial frame is discarded. A frame already being serialized finishes normally.
- **`run` rising edge:** clears `overrun`. It does not clear the counters.

## Timing
- **Reset values:** all outputs 0 (`M_AXIS_tvalid`=0, `M_AXIS_tlast`=0, `M_AXIS_tdata`=0, counters 0, `overrun`=0); state IDLE; accumulators 0; cnt 0.
- **Frame latency:** the completing strobe is at cycle T. r[] and the header are registered at T+1, and `M_AXIS_tvalid`=1 with the header starting at T+1.
- **Handshake rules:**
  - A word transfers when `M_AXIS_tvalid` && `M_AXIS_tready`.
  - `M_AXIS_tdata` and `M_AXIS_tlast` are stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on reset.
- **Throughput:** 1 word/cycle with tready held high. A frame of k+1 words occupies k+1 cycles.
- **Simultaneous events:** if a frame completes in the same cycle as the final tlast handshake, the state is treated as not IDLE and the frame is dropped. Guaranteed minimum: N ≥ popcount(mask)+2 samples at full strobe rate gives zero drops with tready=1.
- **Asynchronous reset:** reset mid-frame forces IDLE and all reset values immediately.

## Test plan
1. **Basic averaging.**
   - Stimulus: N=4, shift=2, mask=6'b000011; ch1 = 10, 20, 30, 40 and ch2 = -4 constant; strobe every cycle; tready=1.
   - Required: frame A5_03_0000, 25, -4 (0xFFFFFFFC), with tlast on the third word; `frame_count`=1.
2. **Saturation.**
   - Stimulus: N=2, shift=0, ch3 = 0x7FFFFFFF both samples, mask=6'b000100.
   - Required: data word 0x7FFFFFFF.
   - Repeat with 0x80000000; required: 0x80000000.
3. **Back-pressure.**
   - Stimulus: tready toggling 1,0,0,1 during a 7-word frame (mask=6'h3F).
   - Required: tdata and tlast are held during the stalls, all 7 words arrive in order, and tlast is on word 7 only.
4. **Overrun.**
   - Stimulus: N=1, mask=6'h3F, tready=0 for 20 cycles with strobe every cycle.
   - Required: `overrun`=1, `overrun_count`=20, and the first frame is intact after tready=1.
   - Then toggle `run` 0→1; required: `overrun`=0 while the count remains.
5. **Edge configurations.**
   - Stimulus: decimation=0, mask=0.
   - Required: a header-only frame per strobe with tlast=1.
   - Stimulus: change mask mid-frame.
   - Required: the change applies to the next frame only.
6. **Reset mid-frame.**
   - Stimulus: assert `a_resetn`=0 during DATA.
   - Required: tvalid=0 immediately; after release, the first frame header shows `frame_count`=0.
